// File: rtl/reg_file.sv
// RV32I integer register file: 32 x XLEN flops, two combinational read ports,
// one synchronous write port; x0 is hardwired to zero.
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we3,
  input  logic [AW-1:0]   a1,
  input  logic [AW-1:0]   a2,
  input  logic [AW-1:0]   a3,
  input  logic [XLEN-1:0] wd3,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];

  // Writes to x0 are dropped here so entry 0 stays at its reset value.
  always_comb begin
    regs_d = regs_q;
    if (we3 && (a3 != '0)) begin
      regs_d[a3] = wd3;
    end
  end

  // Reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports see only committed state: no write-through bypass.
  assign rd1 = (a1 == '0) ? '0 : regs_q[a1];
  assign rd2 = (a2 == '0) ? '0 : regs_q[a2];

endmodule

// File: tb/tb_reg_file.sv
// Randomised self-checking bench for reg_file against an array-based model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we3 = 1'b0;
  logic [4:0]  a1 = '0;
  logic [4:0]  a2 = '0;
  logic [4:0]  a3 = '0;
  logic [31:0] wd3 = '0;
  logic [31:0] rd1;
  logic [31:0] rd2;

  logic [31:0] model [32];
  int n_chk = 0;
  int n_fail = 0;

  reg_file #(.XLEN(32), .NREGS(32)) dut (
    .clk  (clk),
    .reset(reset),
    .we3  (we3),
    .a1   (a1),
    .a2   (a2),
    .a3   (a3),
    .wd3  (wd3),
    .rd1  (rd1),
    .rd2  (rd2)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expect_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : model[a];
  endfunction

  // One clock edge, then fold the edge's effect into the model.
  task automatic tick();
    logic        r;
    logic        w;
    logic [4:0]  wa;
    logic [31:0] wd;
    r = reset; w = we3; wa = a3; wd = wd3;
    @(posedge clk);
    #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (w && wa != 5'd0) begin
      model[wa] = wd;
    end
  endtask

  task automatic read_chk(input string tag, input logic [4:0] x1, input logic [4:0] x2);
    a1 = x1;
    a2 = x2;
    #1;
    check($sformatf("%s rd1 x%0d", tag, x1), rd1, expect_rd(x1));
    check($sformatf("%s rd2 x%0d", tag, x2), rd2, expect_rd(x2));
  endtask

  task automatic sweep_zero(input string tag);
    for (int i = 0; i < 32; i++) begin
      a1 = i[4:0];
      a2 = 5'(31 - i);
      #1;
      check($sformatf("%s rd1 x%0d", tag, i), rd1, 32'h0);
      check($sformatf("%s rd2 x%0d", tag, 31 - i), rd2, 32'h0);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(negedge clk);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    sweep_zero("reset");

    we3 = 1'b1; a3 = 5'd1; wd3 = 32'd42;
    tick();
    we3 = 1'b0;
    a1 = 5'd1;
    #1;
    check("basic x1", rd1, 32'd42);

    we3 = 1'b1; a3 = 5'd0; wd3 = 32'd99;
    tick();
    we3 = 1'b0;
    a1 = 5'd0;
    #1;
    check("x0 protect", rd1, 32'h0);
    a1 = 5'd1;
    #1;
    check("x0 keeps x1", rd1, 32'd42);

    a1 = 5'd1; a2 = 5'd0;
    #1;
    check("dual rd1", rd1, 32'd42);
    check("dual rd2", rd2, 32'h0);
    a2 = 5'd1;
    #1;
    check("same rd1", rd1, 32'd42);
    check("same rd2", rd2, 32'd42);

    we3 = 1'b0; a3 = 5'd5; wd3 = 32'hDEAD_BEEF;
    tick();
    a1 = 5'd5;
    #1;
    check("we gate x5", rd1, 32'h0);
    we3 = 1'b1;
    #1;
    check("no bypass pre", rd1, 32'h0);
    tick();
    we3 = 1'b0;
    #1;
    check("write post", rd1, 32'hDEAD_BEEF);

    for (int k = 1; k < 32; k++) begin
      we3 = 1'b1; a3 = k[4:0]; wd3 = k * 3 + 1;
      tick();
    end
    we3 = 1'b0;
    for (int k = 0; k < 32; k++) begin
      a1 = k[4:0];
      a2 = k[4:0];
      #1;
      check($sformatf("sweep rd1 x%0d", k), rd1, (k == 0) ? 32'h0 : 32'(k * 3 + 1));
      check($sformatf("sweep rd2 x%0d", k), rd2, (k == 0) ? 32'h0 : 32'(k * 3 + 1));
    end

    reset = 1'b1; we3 = 1'b1; a3 = 5'd7; wd3 = 32'd123;
    tick();
    reset = 1'b0; we3 = 1'b0;
    sweep_zero("rst prio");

    // Random traffic: reads checked before each edge (old data) and after it.
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 24) == 0);
      we3   = $urandom_range(0, 3) != 0;
      a3    = 5'($urandom_range(0, 31));
      wd3   = $urandom;
      read_chk("rnd pre", a3, 5'($urandom_range(0, 31)));
      tick();
      reset = 1'b0;
      we3 = 1'b0;
      read_chk("rnd post", a3, 5'($urandom_range(0, 31)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
